// File: rtl/uart_rx_os_if.sv
// Receive-side handshake bundle for uart_rx_os.
// master drives the byte and its status flags; slave returns rx_ready.
interface uart_rx_os_if #(
  parameter int DBIT = 8
);
  logic            rx_valid;
  logic            rx_ready;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            overrun;
  logic            parity_err;

  modport master (
    output rx_valid,
    output dout,
    output frame_err,
    output overrun,
    output parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  dout,
    input  frame_err,
    input  overrun,
    input  parity_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver driven by a OS x baud sample strobe.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_os #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_tick,
  input  logic          rx,
  uart_rx_os_if.master  bus
);

  localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OS/2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t          r_state, w_state_n;
  logic [SW-1:0]   r_s, w_s_n;
  logic [NW-1:0]   r_n, w_n_n;
  logic [DBIT-1:0] r_b, w_b_n;
  logic            r_sync1, r_sync2;
  logic            w_rx;
  logic            w_done;

  logic            r_valid;
  logic [DBIT-1:0] r_dout;
  logic            r_ferr;
  logic            r_ovr;

`ifdef UART_RX_PARITY_EN
  logic            r_par, w_par_n;
  logic            r_perr;
`endif

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_s     <= w_s_n;
      r_n     <= w_n_n;
      r_b     <= w_b_n;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_s_n     = r_s;
    w_n_n     = r_n;
    w_b_n     = r_b;
    w_done    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_n   = r_par;
`endif
    unique case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_state_n = START;
          w_s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (r_s == S_MID) begin
            w_s_n = '0;
            if (!w_rx) begin
              w_state_n = DATA;
              w_n_n     = '0;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_s_n = '0;
            w_b_n = {w_rx, r_b[DBIT-1:1]};
            if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_n = PARITY;
`else
              w_state_n = STOP;
`endif
            end else begin
              w_n_n = r_n + 1'b1;
            end
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (r_s == S_BIT) begin
            w_s_n     = '0;
            w_par_n   = w_rx;
            w_state_n = STOP;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (r_s == S_STOP) begin
            w_s_n     = '0;
            w_done    = 1'b1;
            w_state_n = IDLE;
          end else begin
            w_s_n = r_s + 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // A completing byte always wins over a same-cycle consume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else if (w_done) begin
      r_valid <= 1'b1;
      r_dout  <= r_b;
      r_ferr  <= ~w_rx;
`ifdef UART_RX_PARITY_EN
      r_perr  <= (^r_b) ^ r_par;
`endif
      if (r_valid && !bus.rx_ready) begin
        r_ovr <= 1'b1;
      end
    end else if (r_valid && bus.rx_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.rx_valid  = r_valid;
  assign bus.dout      = r_dout;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
